// File: rtl/xor_checksum_pkg.sv
// Shared types and constants for the XOR/XNOR frame checksum block.
// The FSM state encoding and the frame-mode encoding live here so sub-blocks agree.
package xor_checksum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic MODE_XOR  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/xor_checksum_if.sv
// Beat-in / result-out handshake bundle for xor_checksum.
// The slave modport is the checksum block; the master modport is whatever feeds it and drains results.
interface xor_checksum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    import xor_checksum_pkg::*;

    logic             xnor_mode;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             s_abort;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_sum;
    logic             m_parity;
    logic [CNT_W-1:0] m_count;
    logic             m_ovf;

    modport slave (
        input  xnor_mode,
        input  s_valid,
        output s_ready,
        input  s_data,
        input  s_last,
        input  s_abort,
        output m_valid,
        input  m_ready,
        output m_sum,
        output m_parity,
        output m_count,
        output m_ovf
    );

    modport master (
        output xnor_mode,
        output s_valid,
        input  s_ready,
        output s_data,
        output s_last,
        output s_abort,
        input  m_valid,
        output m_ready,
        input  m_sum,
        input  m_parity,
        input  m_count,
        input  m_ovf
    );

endinterface

// File: rtl/xor_checksum_satcnt.sv
// Saturating beat counter. clear and inc together load 1 so the first beat of a
// frame can restart the count in a single cycle.
module xor_checksum_satcnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign sat   = &count_reg;
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = inc ? CNT_W'(1) : '0;
        end else if (inc && !sat) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/xor_checksum.sv
// Frame checksum: XORs every accepted beat of a frame and presents the result
// (optionally inverted) with beat count and overflow until the sink accepts it.
module xor_checksum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    xor_checksum_if.slave  bus
);
    import xor_checksum_pkg::*;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic             mode_reg;
    logic             mode_next;
    logic             ovf_reg;
    logic             ovf_next;

    logic             cnt_clear;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_sat;

    logic             ready;
    logic             hold;
    logic [WIDTH-1:0] sum_out;

    xor_checksum_satcnt #(
        .CNT_W (CNT_W)
    ) u_satcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (cnt_value),
        .sat   (cnt_sat)
    );

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        mode_next  = mode_reg;
        ovf_next   = ovf_reg;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        ready      = 1'b1;

        case (state_reg)
            IDLE: begin
                // Abort is deliberately not looked at here: a beat always opens a frame.
                cnt_clear = 1'b1;
                ovf_next  = 1'b0;
                acc_next  = '0;
                if (bus.s_valid) begin
                    acc_next   = bus.s_data;
                    mode_next  = bus.xnor_mode;
                    cnt_inc    = 1'b1;
                    state_next = bus.s_last ? HOLD : ACCUM;
                end
            end

            ACCUM: begin
                if (bus.s_abort) begin
                    // Abort wins over any beat on the same edge, including a last beat.
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_clear  = 1'b1;
                    state_next = IDLE;
                end else if (bus.s_valid) begin
                    acc_next = acc_reg ^ bus.s_data;
                    cnt_inc  = 1'b1;
                    ovf_next = ovf_reg | cnt_sat;
                    if (bus.s_last) begin
                        state_next = HOLD;
                    end
                end
            end

            HOLD: begin
                ready = 1'b0;
                if (bus.m_ready) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_clear  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            mode_reg  <= MODE_XOR;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            mode_reg  <= mode_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign hold = (state_reg == HOLD);

    // Result bits come straight from registers and are forced to zero outside HOLD.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
        assign sum_out[gi] = hold & (acc_reg[gi] ^ (mode_reg == MODE_XNOR));
    end

    assign bus.s_ready  = ready;
    assign bus.m_valid  = hold;
    assign bus.m_sum    = sum_out;
    assign bus.m_parity = ^sum_out;
    assign bus.m_count  = hold ? cnt_value : '0;
    assign bus.m_ovf    = hold & ovf_reg;

endmodule

// File: tb/tb_xor_checksum.sv
// Directed checks for xor_checksum: a default-width instance and a CNT_W=2 instance
// share the same stimulus so saturation can be observed on the narrow counter.
`timescale 1ns/1ps
module tb_xor_checksum;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    xor_checksum_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
    xor_checksum_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    xor_checksum #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    xor_checksum #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    assign bus2.xnor_mode = bus8.xnor_mode;
    assign bus2.s_valid   = bus8.s_valid;
    assign bus2.s_data    = bus8.s_data;
    assign bus2.s_last    = bus8.s_last;
    assign bus2.s_abort   = bus8.s_abort;
    assign bus2.m_ready   = bus8.m_ready;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic abort);
        bus8.s_valid = 1'b1;
        bus8.s_data  = d;
        bus8.s_last  = last;
        bus8.s_abort = abort;
        step();
        bus8.s_valid = 1'b0;
        bus8.s_data  = 8'h00;
        bus8.s_last  = 1'b0;
        bus8.s_abort = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_ready"},  64'(bus8.s_ready),  64'd1);
        check({tag, "_m_valid"},  64'(bus8.m_valid),  64'd0);
        check({tag, "_m_sum"},    64'(bus8.m_sum),    64'd0);
        check({tag, "_m_parity"}, 64'(bus8.m_parity), 64'd0);
        check({tag, "_m_count"},  64'(bus8.m_count),  64'd0);
        check({tag, "_m_ovf"},    64'(bus8.m_ovf),    64'd0);
    endtask

    task automatic drain(input string tag);
        bus8.m_ready = 1'b1;
        step();
        bus8.m_ready = 1'b0;
        check({tag, "_drained_valid"}, 64'(bus8.m_valid), 64'd0);
        check({tag, "_drained_ready"}, 64'(bus8.s_ready), 64'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus8.xnor_mode = 1'b0;
        bus8.s_valid   = 1'b0;
        bus8.s_data    = 8'h00;
        bus8.s_last    = 1'b0;
        bus8.s_abort   = 1'b0;
        bus8.m_ready   = 1'b0;

        step();
        step();
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // XOR frame 0F ^ F0 ^ 33 = CC
        beat(8'h0F, 1'b0, 1'b0);
        beat(8'hF0, 1'b0, 1'b0);
        check("xor_not_yet_valid", 64'(bus8.m_valid), 64'd0);
        beat(8'h33, 1'b1, 1'b0);
        check("xor_valid",  64'(bus8.m_valid),  64'd1);
        check("xor_sum",    64'(bus8.m_sum),    64'hCC);
        check("xor_parity", 64'(bus8.m_parity), 64'd0);
        check("xor_count",  64'(bus8.m_count),  64'd3);
        check("xor_ovf",    64'(bus8.m_ovf),    64'd0);
        check("xor_count_w2", 64'(bus2.m_count), 64'd3);
        check("xor_ovf_w2",   64'(bus2.m_ovf),   64'd0);
        check("xor_hold_ready", 64'(bus8.s_ready), 64'd0);
        drain("xor");

        // XNOR single beat: ~A5 = 5A; mode dropped right after so only the latch matters
        bus8.xnor_mode = 1'b1;
        beat(8'hA5, 1'b1, 1'b0);
        bus8.xnor_mode = 1'b0;
        check("xnor_valid",  64'(bus8.m_valid),  64'd1);
        check("xnor_sum",    64'(bus8.m_sum),    64'h5A);
        check("xnor_parity", 64'(bus8.m_parity), 64'd0);
        check("xnor_count",  64'(bus8.m_count),  64'd1);
        drain("xnor");

        // Mode flipped mid-frame is ignored: 01 ^ 02 = 03 in XOR
        beat(8'h01, 1'b0, 1'b0);
        bus8.xnor_mode = 1'b1;
        beat(8'h02, 1'b1, 1'b0);
        bus8.xnor_mode = 1'b0;
        check("midmode_sum",    64'(bus8.m_sum),    64'h03);
        check("midmode_parity", 64'(bus8.m_parity), 64'd0);
        drain("midmode");

        // Backpressure: result held for 5 cycles, a competing beat is refused
        beat(8'h3C, 1'b1, 1'b0);
        bus8.s_valid = 1'b1;
        bus8.s_data  = 8'hFF;
        bus8.s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_s_ready", i), 64'(bus8.s_ready), 64'd0);
            check($sformatf("bp%0d_valid", i),   64'(bus8.m_valid), 64'd1);
            check($sformatf("bp%0d_sum", i),     64'(bus8.m_sum),   64'h3C);
            check($sformatf("bp%0d_count", i),   64'(bus8.m_count), 64'd1);
            step();
        end
        bus8.s_valid = 1'b0;
        bus8.s_last  = 1'b0;
        bus8.s_data  = 8'h00;
        drain("bp");
        beat(8'h55, 1'b1, 1'b0);
        check("bp_next_valid", 64'(bus8.m_valid), 64'd1);
        check("bp_next_sum",   64'(bus8.m_sum),   64'h55);
        check("bp_next_count", 64'(bus8.m_count), 64'd1);
        drain("bp_next");

        // Abort on a last beat: no result, next frame starts clean
        beat(8'h11, 1'b0, 1'b0);
        beat(8'h22, 1'b0, 1'b0);
        beat(8'h44, 1'b1, 1'b1);
        check("abort_no_valid", 64'(bus8.m_valid), 64'd0);
        check("abort_ready",    64'(bus8.s_ready), 64'd1);
        step();
        check("abort_still_no_valid", 64'(bus8.m_valid), 64'd0);
        beat(8'h01, 1'b1, 1'b0);
        check("post_abort_valid",  64'(bus8.m_valid),  64'd1);
        check("post_abort_sum",    64'(bus8.m_sum),    64'h01);
        check("post_abort_parity", 64'(bus8.m_parity), 64'd1);
        check("post_abort_count",  64'(bus8.m_count),  64'd1);
        check("post_abort_ovf",    64'(bus8.m_ovf),    64'd0);
        drain("post_abort");

        // Five beats of FF: narrow counter saturates at 3 and flags overflow
        for (int i = 0; i < 5; i++) begin
            beat(8'hFF, (i == 4), 1'b0);
        end
        check("sat_w2_valid", 64'(bus2.m_valid), 64'd1);
        check("sat_w2_count", 64'(bus2.m_count), 64'd3);
        check("sat_w2_ovf",   64'(bus2.m_ovf),   64'd1);
        check("sat_w2_sum",   64'(bus2.m_sum),   64'hFF);
        check("sat_w8_count", 64'(bus8.m_count), 64'd5);
        check("sat_w8_ovf",   64'(bus8.m_ovf),   64'd0);
        drain("sat");
        check("sat_w2_cleared_ovf", 64'(bus2.m_ovf), 64'd0);

        // Reset after two beats discards the frame
        beat(8'h12, 1'b0, 1'b0);
        beat(8'h34, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        step();
        check("midrst_after_valid", 64'(bus8.m_valid), 64'd0);
        beat(8'h56, 1'b1, 1'b0);
        check("midrst_next_sum",   64'(bus8.m_sum),   64'h56);
        check("midrst_next_count", 64'(bus8.m_count), 64'd1);
        drain("midrst_next");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_checksum.md
XOR_CHECKSUM -- requirements
Module: xor_checksum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data and checksum width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the beat-counter width in bits (legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port xnor_mode, input, 1, selecting the frame mode; it is sampled only on the first accepted beat of a frame (0 = XOR, 1 = XNOR).
REQ-006 The block SHALL have port s_valid, input, 1, input beat valid.
REQ-007 The block SHALL have port s_ready, output, 1, input beat ready.
REQ-008 The block SHALL have port s_data, input, WIDTH, input beat data.
REQ-009 The block SHALL have port s_last, input, 1, final beat of the frame.
REQ-010 The block SHALL have port s_abort, input, 1, discard the frame in progress.
REQ-011 The block SHALL have port m_valid, output, 1, result valid.
REQ-012 The block SHALL have port m_ready, input, 1, result accepted.
REQ-013 The block SHALL have port m_sum, output, WIDTH, the frame checksum.
REQ-014 The block SHALL have port m_parity, output, 1, the XOR-reduction of m_sum.
REQ-015 The block SHALL have port m_count, output, CNT_W, the number of beats in the frame, saturating.
REQ-016 The block SHALL have port m_ovf, output, 1, set when the beat count saturated.

Function
REQ-017 A beat SHALL be accepted when s_valid and s_ready are both 1 on a rising edge.
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-019 In IDLE and ACCUM, s_ready SHALL be 1; in HOLD, s_ready SHALL be 0.
REQ-020 An accepted beat in IDLE SHALL load acc = s_data, set count = 1, latch the mode, and go to ACCUM, or to HOLD if s_last is 1.
REQ-021 An accepted beat in ACCUM SHALL set acc = acc XOR s_data and increment count; the FSM SHALL go to HOLD if s_last is 1.
REQ-022 Count SHALL saturate at 2^CNT_W-1; an accepted beat while count is already saturated SHALL set the frame's overflow flag.
REQ-023 In HOLD, m_valid SHALL be 1 and m_sum SHALL be acc (XOR mode) or ~acc (XNOR mode); m_parity, m_count and m_ovf SHALL be stable while m_valid is 1.
REQ-024 Latency: m_valid SHALL rise on the edge that accepts the s_last beat, so it is visible in the following cycle.
REQ-025 In HOLD, the result SHALL be held until m_ready is 1; on that edge the FSM SHALL return to IDLE with no bubble, and the next frame may start in the next cycle.
REQ-026 s_abort sampled as 1 in ACCUM SHALL return the FSM to IDLE and clear acc, count and the overflow flag; any beat on the same edge SHALL be discarded.
REQ-027 s_abort SHALL be ignored in IDLE (an accepted beat still starts a frame) and in HOLD.
REQ-028 A simultaneous s_last beat and s_abort in ACCUM SHALL be treated as an abort, with no result produced.
REQ-029 xnor_mode changes in the middle of a frame SHALL have no effect on that frame.
REQ-030 When m_valid is 0, m_sum, m_parity, m_count and m_ovf SHALL read 0.

Reset
REQ-031 While rst_n is 0 at a rising edge, the FSM SHALL go to IDLE and acc, count, the overflow flag and the latched mode SHALL clear to 0.
REQ-032 Output values during and immediately after reset SHALL be: s_ready = 1, m_valid = 0, m_sum = 0, m_parity = 0, m_count = 0, m_ovf = 0.
REQ-033 Reset asserted mid-frame or in HOLD SHALL discard the frame or the pending result with no output.

Structure
REQ-034 The state enum (IDLE/ACCUM/HOLD) and the mode encoding constants SHALL live in package xor_checksum_pkg.
REQ-035 The saturating beat counter SHALL be one sub-module, xor_checksum_satcnt, parameterised by CNT_W, with inputs clear, inc and outputs count, sat.
REQ-036 The datapath SHALL contain no combinational path from s_data to m_sum; m_sum is driven from registers.

Verification
REQ-037 The bench SHALL cover XOR frame, WIDTH=8: beats 0x0F, 0xF0, 0x33 with last on the third -> m_sum=0xCC, m_parity=0, m_count=3, m_ovf=0, m_valid one cycle after the last beat.
REQ-038 The bench SHALL cover an XNOR single-beat frame: xnor_mode=1, beat 0xA5 with s_last -> m_sum=0x5A, m_parity=0, m_count=1.
REQ-039 The bench SHALL cover backpressure: m_ready held 0 for 5 cycles -> s_ready=0 and outputs stable throughout; m_ready=1 -> IDLE, and a new frame is accepted in the next cycle.
REQ-040 The bench SHALL cover abort: beats 0x11, 0x22, then s_abort with a s_last beat -> no m_valid; the next frame, beat 0x01 with last -> m_sum=0x01, m_count=1.
REQ-041 The bench SHALL cover saturation, CNT_W=2: a 5-beat frame of 0xFF -> m_count=3, m_ovf=1, m_sum=0xFF.
REQ-042 The bench SHALL cover reset mid-frame: rst_n=0 for one cycle after 2 beats -> all outputs at reset values and no result is produced.
